// File: rtl/pipe_exe_mem.sv
// -----------------------------------------------------------------------------
// pipe_exe_mem -- execute-to-memory pipeline register with a 2-entry skid buffer.
//
// Holds up to two in-order entries (head, tail) between the execute and memory
// stages. The memory stage always sees the head entry. inReady is registered,
// so there is no combinational path from outReady back to the execute stage.
// It also exposes a forwarding source (the youngest held entry) and a
// saturating backpressure counter.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   flush        : synchronous discard of all held entries and of same-cycle input
//   inValid      : execute stage presents an entry
//   inReady      : stage can accept an entry this cycle (registered)
//   aluResIn     : ALU result / memory address
//   storeDataIn  : store data
//   rdIn         : destination register index
//   ctrlIn       : {regWrite, memToReg, memWrite}
//   outValid     : head entry valid toward memory stage
//   outReady     : memory stage accepts head entry
//   aluResOut, storeDataOut, rdOut, ctrlOut : head entry fields
//   fwdValid, fwdRd, fwdData : forwarding source for execute
//   stallCount   : saturating count of cycles with outValid && !outReady
// -----------------------------------------------------------------------------
module pipe_exe_mem #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              inValid,
    output logic              inReady,
    input  logic [DATA_W-1:0] aluResIn,
    input  logic [DATA_W-1:0] storeDataIn,
    input  logic [RD_W-1:0]   rdIn,
    input  logic [2:0]        ctrlIn,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] aluResOut,
    output logic [DATA_W-1:0] storeDataOut,
    output logic [RD_W-1:0]   rdOut,
    output logic [2:0]        ctrlOut,
    output logic              fwdValid,
    output logic [RD_W-1:0]   fwdRd,
    output logic [DATA_W-1:0] fwdData,
    output logic [15:0]       stallCount
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] store;
        logic [RD_W-1:0]   rd;
        logic [2:0]        ctrl;   // {regWrite, memToReg, memWrite}
    } entry_t;

    state_e      state_q, state_d;
    entry_t      head_q, head_d;
    entry_t      tail_q, tail_d;
    entry_t      in_entry;
    entry_t      youngest;
    logic        in_ready_q, in_ready_d;
    logic [15:0] stall_q, stall_d;
    logic        accept;
    logic        release_head;

    assign in_entry     = '{alu: aluResIn, store: storeDataIn, rd: rdIn, ctrl: ctrlIn};
    assign outValid     = (state_q != EMPTY);
    assign accept       = inValid && in_ready_q && !flush;
    assign release_head = outValid && outReady && !flush;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;

        if (flush) begin
            // Data registers keep their contents; only the state hides them.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_d  = in_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && release_head) begin
                        head_d = in_entry;
                    end else if (accept) begin
                        tail_d  = in_entry;
                        state_d = TWO;
                    end else if (release_head) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // inReady is low in TWO, so only a release can happen.
                    if (release_head) begin
                        head_d  = tail_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        // Registered ready: computed from the next state, not from outReady.
        in_ready_d = (state_d != TWO);

        stall_d = stall_q;
        if (outValid && !outReady && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // NOTE: state uses non-blocking assignments so all registers update
    // together from values sampled before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            // NOTE: the entry registers are reset (only two of them) because
            // every data output must read zero while reset is held.
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= in_ready_d;
            stall_q    <= stall_d;
        end
    end

    assign inReady      = in_ready_q;
    assign aluResOut    = head_q.alu;
    assign storeDataOut = head_q.store;
    assign rdOut        = head_q.rd;
    assign ctrlOut      = head_q.ctrl;
    assign stallCount   = stall_q;

    // Forward from the youngest held entry; loads (memToReg) cannot forward
    // because their value is not known until the memory stage.
    assign youngest = (state_q == TWO) ? tail_q : head_q;
    assign fwdValid = outValid && youngest.ctrl[2] && !youngest.ctrl[1];
    assign fwdRd    = outValid ? youngest.rd  : '0;
    assign fwdData  = outValid ? youngest.alu : '0;

endmodule

// File: tb/tb_pipe_exe_mem.sv
// -----------------------------------------------------------------------------
// tb_pipe_exe_mem -- directed self-checking bench for pipe_exe_mem.
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_pipe_exe_mem;

    localparam int DATA_W = 32;
    localparam int RD_W   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              inValid;
    logic              inReady;
    logic [DATA_W-1:0] aluResIn;
    logic [DATA_W-1:0] storeDataIn;
    logic [RD_W-1:0]   rdIn;
    logic [2:0]        ctrlIn;
    logic              outValid;
    logic              outReady;
    logic [DATA_W-1:0] aluResOut;
    logic [DATA_W-1:0] storeDataOut;
    logic [RD_W-1:0]   rdOut;
    logic [2:0]        ctrlOut;
    logic              fwdValid;
    logic [RD_W-1:0]   fwdRd;
    logic [DATA_W-1:0] fwdData;
    logic [15:0]       stallCount;

    int tests_run = 0;
    int tests_failed = 0;

    pipe_exe_mem #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .inValid      (inValid),
        .inReady      (inReady),
        .aluResIn     (aluResIn),
        .storeDataIn  (storeDataIn),
        .rdIn         (rdIn),
        .ctrlIn       (ctrlIn),
        .outValid     (outValid),
        .outReady     (outReady),
        .aluResOut    (aluResOut),
        .storeDataOut (storeDataOut),
        .rdOut        (rdOut),
        .ctrlOut      (ctrlOut),
        .fwdValid     (fwdValid),
        .fwdRd        (fwdRd),
        .fwdData      (fwdData),
        .stallCount   (stallCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [3:0] rd,
                         input logic [2:0] ctrl);
        inValid     = v;
        aluResIn    = alu;
        storeDataIn = ~alu;
        rdIn        = rd;
        ctrlIn      = ctrl;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; outReady = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 3'b000);

        // Reset held: all outputs at reset values, even across clock edges.
        #3;
        check("rst_inReady", inReady, 0);
        check("rst_outValid", outValid, 0);
        check("rst_fwdValid", fwdValid, 0);
        check("rst_alu", aluResOut, 0);
        check("rst_stall", stallCount, 0);
        drive(1'b1, 32'h77, 4'h7, 3'b100);
        tick(); tick();
        check("rst_hold_inReady", inReady, 0);
        check("rst_hold_outValid", outValid, 0);
        drive(1'b0, 32'h0, 4'h0, 3'b000);
        rst = 1'b1;
        tick();
        check("post_rst_inReady", inReady, 1);
        check("post_rst_outValid", outValid, 0);

        // Single entry, outReady=1.
        outReady = 1'b1;
        drive(1'b1, 32'h0000_0010, 4'd3, 3'b100);
        tick();
        drive(1'b0, 32'h0, 4'h0, 3'b000);
        check("single_valid", outValid, 1);
        check("single_alu", aluResOut, 32'h10);
        check("single_store", storeDataOut, 32'hFFFF_FFEF);
        check("single_rd", rdOut, 3);
        check("single_ctrl", ctrlOut, 3'b100);
        check("single_fwdValid", fwdValid, 1);
        check("single_fwdRd", fwdRd, 3);
        check("single_fwdData", fwdData, 32'h10);
        tick();
        check("single_gone", outValid, 0);
        check("single_fwd_gone", fwdValid, 0);
        check("single_stall", stallCount, 0);

        // Backpressure: fill with A then B, then drain in order.
        outReady = 1'b0;
        drive(1'b1, 32'hA, 4'd1, 3'b100);
        tick();
        check("bp_one_ready", inReady, 1);
        check("bp_one_fwdRd", fwdRd, 1);
        drive(1'b1, 32'hB, 4'd2, 3'b110);
        tick();
        check("bp_two_ready", inReady, 0);
        check("bp_two_head", aluResOut, 32'hA);
        check("bp_two_fwdValid", fwdValid, 0);
        check("bp_two_stall", stallCount, 1);
        drive(1'b1, 32'hC, 4'd9, 3'b100);   // ignored: inReady is low
        tick(); tick();
        check("bp_head_stable", aluResOut, 32'hA);
        check("bp_rd_stable", rdOut, 1);
        check("bp_stall3", stallCount, 3);
        drive(1'b0, 32'h0, 4'h0, 3'b000);
        outReady = 1'b1;
        tick();
        check("bp_drain_B", aluResOut, 32'hB);
        check("bp_drain_rd", rdOut, 2);
        check("bp_drain_ready", inReady, 1);
        check("bp_drain_valid", outValid, 1);
        check("bp_drain_stall", stallCount, 3);
        tick();
        check("bp_empty", outValid, 0);

        // ONE with simultaneous accept and release.
        outReady = 1'b0;
        drive(1'b1, 32'hD, 4'd4, 3'b100);
        tick();
        outReady = 1'b1;
        drive(1'b1, 32'hC, 4'd6, 3'b101);
        tick();
        drive(1'b0, 32'h0, 4'h0, 3'b000);
        check("swap_head", aluResOut, 32'hC);
        check("swap_rd", rdOut, 6);
        check("swap_valid", outValid, 1);
        check("swap_ready", inReady, 1);
        tick();
        check("swap_empty", outValid, 0);

        // Flush while TWO with inValid=1.
        outReady = 1'b0;
        drive(1'b1, 32'hE, 4'd5, 3'b100);
        tick();
        drive(1'b1, 32'hF, 4'd8, 3'b100);
        tick();
        check("fl_two_ready", inReady, 0);
        check("fl_two_fwdRd", fwdRd, 8);
        flush = 1'b1;
        drive(1'b1, 32'h99, 4'd2, 3'b100);
        tick();
        check("fl_valid", outValid, 0);
        check("fl_ready", inReady, 1);
        check("fl_fwdValid", fwdValid, 0);
        check("fl_stall_kept", stallCount, 5);
        // Flush while ONE with inReady=1: input must still be discarded.
        flush = 1'b0;
        drive(1'b1, 32'h12, 4'd1, 3'b100);
        tick();
        flush = 1'b1;
        drive(1'b1, 32'h34, 4'd2, 3'b100);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 3'b000);
        check("fl1_valid", outValid, 0);
        tick();
        check("fl1_still_empty", outValid, 0);
        check("fl1_stall", stallCount, 6);

        // Asynchronous reset between edges while TWO.
        drive(1'b1, 32'h21, 4'd3, 3'b100);
        tick();
        drive(1'b1, 32'h22, 4'd4, 3'b100);
        tick();
        drive(1'b0, 32'h0, 4'h0, 3'b000);
        check("ar_two_ready", inReady, 0);
        #2 rst = 1'b0;
        #1;
        check("ar_valid", outValid, 0);
        check("ar_ready", inReady, 0);
        check("ar_alu", aluResOut, 0);
        check("ar_fwdValid", fwdValid, 0);
        check("ar_stall", stallCount, 0);
        tick();
        rst = 1'b1;
        tick();
        check("ar_post_ready", inReady, 1);
        check("ar_post_valid", outValid, 0);

        // Stall counter saturation.
        drive(1'b1, 32'h55, 4'd7, 3'b100);
        tick();
        drive(1'b0, 32'h0, 4'h0, 3'b000);
        repeat (1000) tick();
        check("sat_1000", stallCount, 1000);
        repeat (65535 - 1000) tick();
        check("sat_max", stallCount, 16'hFFFF);
        repeat (5) tick();
        check("sat_hold", stallCount, 16'hFFFF);
        check("sat_head", aluResOut, 32'h55);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
